// File: rtl/axis_pkg.sv
// Shared types and sizing helpers for the AXI-Stream output packing path.
package axis_pkg;

  localparam int SUM_WIDTH_DEF = 32;
  localparam int BUS_WIDTH_DEF = 32;

  typedef enum logic {IDLE, SEND} state_t;

  function automatic int beats_per_row(input int k, input int s, input int b);
    return k * s / b;
  endfunction

endpackage

// File: rtl/axis_pack_output.sv
// Serializes one wide PE result row into BUS_WIDTH beats, LSB lane first, tlast per frame.
// Latency: first beat valid the cycle after the row handshake; BEATS cycles per row at full rate.
// Backpressure: m_axis_tready=0 freezes all state; the next row is taken only as the last beat leaves.
module axis_pack_output
  import axis_pkg::*;
#(
  parameter int KERNEL_SIZE    = 16,
  parameter int SUM_WIDTH      = SUM_WIDTH_DEF,
  parameter int BUS_WIDTH      = BUS_WIDTH_DEF,
  parameter int ROWS_PER_FRAME = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [KERNEL_SIZE*SUM_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [BUS_WIDTH-1:0]            m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic                            frame_done
);

  localparam int ROW_W = KERNEL_SIZE * SUM_WIDTH;
  localparam int BEATS = beats_per_row(KERNEL_SIZE, SUM_WIDTH, BUS_WIDTH);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS_PER_FRAME - 1);

  state_t            state;
  logic [CW-1:0]     beat_cnt;
  logic [RW-1:0]     row_cnt;
  logic [ROW_W-1:0]  shreg;
  logic              last_beat;
  logic              beat_acc;

  assign last_beat     = (beat_cnt == LAST_BEAT);
  assign beat_acc      = (state == SEND) && m_axis_tready;
  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tdata  = shreg[BUS_WIDTH-1:0];
  assign m_axis_tlast  = (state == SEND) && last_beat && (row_cnt == LAST_ROW);
  // Next row is taken in the same cycle the current row's last beat leaves.
  assign s_axis_tready = !rst && ((state == IDLE) || ((state == SEND) && last_beat && m_axis_tready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      row_cnt    <= '0;
      shreg      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= beat_acc && m_axis_tlast;
      case (state)
        IDLE: begin
          if (s_axis_tvalid) begin
            shreg    <= s_axis_tdata;
            beat_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            if (!last_beat) begin
              shreg    <= shreg >> BUS_WIDTH;
              beat_cnt <= beat_cnt + CW'(1);
            end else begin
              row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + RW'(1);
              if (s_axis_tvalid) begin
                shreg    <= s_axis_tdata;
                beat_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pack_output.sv
// Directed bench for axis_pack_output: default build plus a single-beat, single-row-frame build.
module tb_axis_pack_output;

  localparam int K = 16, S = 32, B = 32, BEATS = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [K*S-1:0] s_tdata = '0;
  logic           s_tvalid = 1'b0;
  logic           s_tready;
  logic [B-1:0]   m_tdata;
  logic           m_tvalid, m_tlast;
  logic           m_tready = 1'b1;
  logic           fd;

  logic [31:0]    s1_tdata = '0;
  logic           s1_tvalid = 1'b0;
  logic           s1_tready;
  logic [31:0]    m1_tdata;
  logic           m1_tvalid, m1_tlast;
  logic           m1_tready = 1'b1;
  logic           fd1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axis_pack_output #(.KERNEL_SIZE(K), .SUM_WIDTH(S), .BUS_WIDTH(B), .ROWS_PER_FRAME(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .frame_done(fd)
  );

  axis_pack_output #(.KERNEL_SIZE(2), .SUM_WIDTH(16), .BUS_WIDTH(32), .ROWS_PER_FRAME(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
    .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tlast(m1_tlast),
    .m_axis_tready(m1_tready), .frame_done(fd1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [K*S-1:0] make_row(input logic [31:0] base, input int r);
    logic [K*S-1:0] v;
    for (int i = 0; i < K; i++) v[i*S +: S] = base + 32'(r * 16 + i);
    return v;
  endfunction

  // Streams nrows rows, checking every cycle; optionally stops while beat abort_beat of row abort_row is on the bus.
  task automatic run_rows(input int nrows, input logic [31:0] base, input int tlast_row,
                          input bit stall, input int abort_row, input int abort_beat);
    int  r_in = 0, r_out = 0, b = 0, cyc = 0;
    bit  busy = 0, fd_exp = 0, tl, exp_srdy, acc_out, acc_in;
    @(negedge clk);
    s_tdata  = make_row(base, 0);
    s_tvalid = 1'b1;
    m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    while (1) begin
      #1;
      tl = busy && (b == BEATS - 1) && (r_out == tlast_row);
      check("m_tvalid", 64'(m_tvalid), 64'(busy));
      check("frame_done", 64'(fd), 64'(fd_exp));
      if (busy) begin
        check("m_tdata", 64'(m_tdata), 64'(base + 32'(r_out * 16 + b)));
        check("m_tlast", 64'(m_tlast), 64'(tl));
      end
      exp_srdy = !busy || ((b == BEATS - 1) && m_tready);
      check("s_tready", 64'(s_tready), 64'(exp_srdy));
      if (busy && r_out == abort_row && b == abort_beat) break;
      acc_out = busy && m_tready;
      acc_in  = s_tvalid && exp_srdy;
      fd_exp  = acc_out && tl;
      if (acc_out) begin
        b++;
        if (b == BEATS) begin b = 0; r_out++; busy = 0; end
      end
      if (acc_in) begin busy = 1; r_in++; end
      @(negedge clk);
      if (r_in < nrows) s_tdata = make_row(base, r_in);
      else s_tvalid = 1'b0;
      m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
      if (r_out == nrows && !busy) begin
        #1;
        check("frame_done_after", 64'(fd), 64'(fd_exp));
        check("m_tvalid_after", 64'(m_tvalid), 64'd0);
        break;
      end
      if (cyc > 3000) begin
        check("timeout", 64'd1, 64'd0);
        break;
      end
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_fd", 64'(fd), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_s_tready", 64'(s_tready), 64'd1);

    // idle with no input
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("idle_tvalid", 64'(m_tvalid), 64'd0);
      check("idle_s_tready", 64'(s_tready), 64'd1);
      check("idle_fd", 64'(fd), 64'd0);
    end

    // full frame back-to-back: tlast on row 15 beat 15 only
    run_rows(16, 32'h0000_2000, 15, 1'b0, -1, -1);
    // single row from row_cnt 0: no tlast
    run_rows(1, 32'h0000_1000, -1, 1'b0, -1, -1);
    // same row with random backpressure
    run_rows(1, 32'h0000_1000, -1, 1'b1, -1, -1);
    // reset during beat 7 of row 3
    run_rows(4, 32'h0000_3000, -1, 1'b0, 3, 7);
    rst = 1'b1;
    s_tvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("midrst_tvalid", 64'(m_tvalid), 64'd0);
      check("midrst_s_tready", 64'(s_tready), 64'd0);
      check("midrst_tlast", 64'(m_tlast), 64'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("postrst_no_beats", 64'(m_tvalid), 64'd0);
    end
    // row counter was cleared: tlast lands on the 16th new row
    run_rows(16, 32'h0000_4000, 15, 1'b0, -1, -1);

    // single-beat build: every beat is a tlast beat with data passed through
    @(negedge clk);
    s1_tdata  = 32'hDEAD_BEEF;
    s1_tvalid = 1'b1;
    m1_tready = 1'b1;
    @(negedge clk);
    #1;
    check("b1_tvalid0", 64'(m1_tvalid), 64'd1);
    check("b1_tdata0", 64'(m1_tdata), 64'hDEAD_BEEF);
    check("b1_tlast0", 64'(m1_tlast), 64'd1);
    check("b1_s_tready0", 64'(s1_tready), 64'd1);
    s1_tdata = 32'h1234_5678;
    @(negedge clk);
    m1_tready = 1'b0;
    #1;
    check("b1_tdata1", 64'(m1_tdata), 64'h1234_5678);
    check("b1_tlast1", 64'(m1_tlast), 64'd1);
    check("b1_s_tready_stall", 64'(s1_tready), 64'd0);
    check("b1_fd_pulse", 64'(fd1), 64'd1);
    @(negedge clk);
    #1;
    check("b1_tdata1_stable", 64'(m1_tdata), 64'h1234_5678);
    check("b1_tlast1_stable", 64'(m1_tlast), 64'd1);
    check("b1_fd_stall", 64'(fd1), 64'd0);
    m1_tready = 1'b1;
    s1_tvalid = 1'b0;
    @(negedge clk);
    #1;
    check("b1_idle_tvalid", 64'(m1_tvalid), 64'd0);
    check("b1_fd_pulse2", 64'(fd1), 64'd1);
    check("b1_idle_s_tready", 64'(s1_tready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_pack_output.md
Name: axis_pack_output

Overview:
- Output serializer between the PE result FIFO and the DMA. It accepts one wide PE result row (KERNEL_SIZE lanes of SUM_WIDTH bits) per AXI-Stream handshake.
- It emits the row as BUS_WIDTH-bit beats, least-significant lane first, on a standard AXI-Stream master.
- It asserts tlast on the final beat of every ROWS_PER_FRAME-th row, so the DMA sees one packet per output frame.
- It is fully pipelined: a new row loads on the same cycle the previous row's last beat is accepted, so there are no bubbles.

Parameters:
- KERNEL_SIZE, 16, lanes per PE result row.
- SUM_WIDTH, 32, bits per lane (DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE).
- BUS_WIDTH, 32, output bus width. KERNEL_SIZE*SUM_WIDTH must be an integer multiple of BUS_WIDTH.
- ROWS_PER_FRAME, 16, rows per tlast packet. Must be at least 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- s_axis_tdata  input  KERNEL_SIZE*SUM_WIDTH  wide PE row from the output FIFO.
- s_axis_tvalid  input  1  row valid.
- s_axis_tready  output  1  block can accept a row this cycle.
- m_axis_tdata  output  BUS_WIDTH  serialized beat to the DMA.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tlast  output  1  last beat of the frame.
- m_axis_tready  input  1  DMA accepts the beat.
- frame_done  output  1  one-cycle pulse when a tlast beat is accepted.

Behaviour:
- Definitions:
  - BEATS = KERNEL_SIZE*SUM_WIDTH/BUS_WIDTH (default 16).
  - beat_cnt is $clog2(BEATS) bits wide (minimum 1).
  - row_cnt is $clog2(ROWS_PER_FRAME) bits wide (minimum 1).
- Reset (synchronous, rst=1 sampled on a clk edge):
  - state=IDLE, beat_cnt=0, row_cnt=0, shift register=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_done=0.
  - s_axis_tready=0 while rst=1.
  - Reset mid-row discards the partial row; no further beats are emitted.
- States:
  - IDLE: m_axis_tvalid=0, s_axis_tready=1. On s_axis_tvalid: load the shift register with s_axis_tdata, set beat_cnt=0, go to SEND.
  - SEND: m_axis_tvalid=1. m_axis_tdata is the shift register bits [BUS_WIDTH-1:0].
    - On m_axis_tready with beat_cnt<BEATS-1: shift right by BUS_WIDTH and increment beat_cnt.
    - On m_axis_tready with beat_cnt==BEATS-1 (last beat): update row_cnt; the row is complete.
      - If s_axis_tvalid is also 1: load the new row, set beat_cnt=0, stay in SEND (zero-bubble).
      - Otherwise: go to IDLE.
- s_axis_tready (combinational) = !rst && (state==IDLE || (state==SEND && beat_cnt==BEATS-1 && m_axis_tready)).
- Latency: the first beat is valid on the cycle after the input handshake. With m_axis_tready held high, one row occupies exactly BEATS cycles.
- m_axis_tlast = (state==SEND) && beat_cnt==BEATS-1 && row_cnt==ROWS_PER_FRAME-1.
- row_cnt on last-beat acceptance: increments, and wraps to 0 after ROWS_PER_FRAME-1.
- frame_done is registered: it is 1 on the cycle after a beat is accepted with m_axis_tlast=1, and 0 otherwise.
- AXI rules:
  - Once m_axis_tvalid=1, tdata and tlast stay stable until m_axis_tready.
  - tvalid never depends combinationally on tready.
  - Backpressure (m_axis_tready=0) freezes all state.
- Corner values:
  - BEATS=1: every accepted beat is a last beat.
  - ROWS_PER_FRAME=1: tlast is set on every row.
- No arithmetic is performed on the data; lanes are passed through bit-exact.

Decomposition:
- Shared package axis_pkg holds:
  - localparams SUM_WIDTH_DEF=32, BUS_WIDTH_DEF=32;
  - a function beats_per_row(k,s,b)=k*s/b;
  - a state enum {IDLE, SEND}, 1 bit.
- The block is a single module, about 150 lines. No sub-module is needed; the counters and shift register are inline.
- The block instantiates at the top level downstream of the output fifo_axis, replacing its direct connection to the DMA.

Test Plan:
- Single row, lane i = 32'h1000+i, m_axis_tready=1 → 16 beats 0x1000..0x100F on consecutive cycles starting 1 cycle after the handshake; tlast=0 (row_cnt 0→1).
- 16 back-to-back rows, s_axis_tvalid held at 1, tready=1 → 256 beats with no gaps. tlast appears only on beat 255. frame_done pulses once, on the cycle after. s_axis_tready is high exactly on beats 15, 31, …, 255.
- Random m_axis_tready at 50% duty → tdata and tlast stay stable across every stall. The beat order is identical to the first scenario. No beats are lost or duplicated (scoreboard check).
- Assert rst=1 at beat 7 of row 3, release, then send 16 rows → no beats after reset. The new frame's tlast lands on row 16 of the new sequence, confirming row_cnt was cleared.
- Parameters ROWS_PER_FRAME=1, KERNEL_SIZE=2, SUM_WIDTH=16, BUS_WIDTH=32 (BEATS=1) → every accepted beat carries tlast=1, and data equals the input row exactly.
- IDLE with s_axis_tvalid=0 for 20 cycles → m_axis_tvalid stays 0, s_axis_tready stays 1, and frame_done stays 0.
